// File: rtl/ff_bank_pkg.sv
// Shared types and the per-bit next-state function for the ff_bank storage bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_t;

  // SR with both inputs high is the illegal pattern; the bit simply holds.
  function automatic logic ff_next(ff_mode_t mode, logic j, logic k, logic q);
    logic nxt;
    nxt = q;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b00:   nxt = q;
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          default: nxt = ~q;
        endcase
      end
      MODE_SR: begin
        case ({j, k})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          default: nxt = q;
        endcase
      end
      MODE_D:  nxt = j;
      default: nxt = q ^ j;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_bank_cell.sv
// One storage bit of ff_bank: registered q, complement and one-cycle change flag.
module ff_bank_cell
  import ff_bank_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic nxt,
  output logic q,
  output logic qbar,
  output logic chg
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= RST_BIT;
      qbar <= ~RST_BIT;
      chg  <= 1'b0;
    end else if (clr) begin
      q    <= RST_BIT;
      qbar <= ~RST_BIT;
      chg  <= q ^ RST_BIT;
    end else if (en) begin
      q    <= nxt;
      qbar <= ~nxt;
      chg  <= q ^ nxt;
    end else begin
      chg  <= 1'b0;
    end
  end

endmodule

// File: rtl/ff_bank.sv
// WIDTH-bit bank of mode-selectable JK/SR/D/T flip-flops with change mask.
// Optional sticky illegal-SR flag enabled by defining FF_BANK_SR_ERR_EN.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] chg,
  output logic             any_chg
`ifdef FF_BANK_SR_ERR_EN
  ,
  output logic             sr_err
`endif
);

  ff_mode_t         mode_e;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] chg_d;

  assign mode_e = ff_mode_t'(mode);

  always_comb begin
    nxt = q;
    for (int i = 0; i < WIDTH; i++) begin
      nxt[i] = ff_next(mode_e, j[i], k[i], q[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_bank_cell #(
      .RST_BIT(RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (clr),
      .nxt (nxt[i]),
      .q   (q[i]),
      .qbar(qbar[i]),
      .chg (chg[i])
    );
  end

  // Mirror of the per-cell change logic so any_chg lands on the same edge as chg.
  always_comb begin
    chg_d = '0;
    if (clr) begin
      chg_d = q ^ RST_VAL;
    end else if (en) begin
      chg_d = q ^ nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_chg <= 1'b0;
    end else begin
      any_chg <= |chg_d;
    end
  end

`ifdef FF_BANK_SR_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_err <= 1'b0;
    end else if (clr) begin
      sr_err <= 1'b0;
    end else if (en && (mode_e == MODE_SR) && (|(j & k))) begin
      sr_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Directed and randomised self-checking bench for ff_bank (WIDTH=4, RST_VAL=1010).
// Checks sr_err too when built with FF_BANK_SR_ERR_EN.
module tb_ff_bank;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b1010;

  logic         clk;
  logic         rst;
  logic         en;
  logic         clr;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic [W-1:0] chg;
  logic         any_chg;
`ifdef FF_BANK_SR_ERR_EN
  logic         sr_err;
`endif

  int checks = 0;
  int fails  = 0;

  ff_bank #(
    .WIDTH  (W),
    .RST_VAL(RV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .mode   (mode),
    .j      (j),
    .k      (k),
    .q      (q),
    .qbar   (qbar),
    .chg    (chg),
    .any_chg(any_chg)
`ifdef FF_BANK_SR_ERR_EN
    ,
    .sr_err (sr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, and settle 1ns past the edge.
  task automatic apply_cycle(input logic [1:0] m, input logic [W-1:0] jv, input logic [W-1:0] kv,
                             input logic e, input logic c);
    mode = m; j = jv; k = kv; en = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; j = '0; k = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (q !== RV) begin fails++; $display("FAIL reset_q got=%b exp=%b", q, RV); end
    checks++; if (qbar !== ~RV) begin fails++; $display("FAIL reset_qbar got=%b exp=%b", qbar, ~RV); end
    checks++; if (chg !== 4'b0000) begin fails++; $display("FAIL reset_chg got=%b exp=0000", chg); end
    checks++; if (any_chg !== 1'b0) begin fails++; $display("FAIL reset_any got=%b exp=0", any_chg); end
`ifdef FF_BANK_SR_ERR_EN
    checks++; if (sr_err !== 1'b0) begin fails++; $display("FAIL reset_srerr got=%b exp=0", sr_err); end
`endif
    @(negedge clk);
    rst = 1'b1;
    apply_cycle(2'b10, 4'b1111, 4'b0000, 1'b0, 1'b0);
    checks++; if (q !== RV) begin fails++; $display("FAIL hold_q got=%b exp=%b", q, RV); end
    checks++; if (chg !== 4'b0000) begin fails++; $display("FAIL hold_chg got=%b exp=0000", chg); end
  endtask

  task automatic test_jk();
    apply_cycle(2'b10, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++; if (q !== 4'b0000) begin fails++; $display("FAIL jk_pre_q got=%b exp=0000", q); end
    apply_cycle(2'b00, 4'b1100, 4'b0101, 1'b1, 1'b0);
    checks++; if (q !== 4'b1100) begin fails++; $display("FAIL jk_mix_q got=%b exp=1100", q); end
    checks++; if (chg !== 4'b1100) begin fails++; $display("FAIL jk_mix_chg got=%b exp=1100", chg); end
    apply_cycle(2'b00, 4'b1111, 4'b1111, 1'b1, 1'b0);
    checks++; if (q !== 4'b0011) begin fails++; $display("FAIL jk_tog_q got=%b exp=0011", q); end
    checks++; if (qbar !== 4'b1100) begin fails++; $display("FAIL jk_tog_qbar got=%b exp=1100", qbar); end
    checks++; if (chg !== 4'b1111) begin fails++; $display("FAIL jk_tog_chg got=%b exp=1111", chg); end
    checks++; if (any_chg !== 1'b1) begin fails++; $display("FAIL jk_tog_any got=%b exp=1", any_chg); end
  endtask

  task automatic test_sr();
    apply_cycle(2'b10, 4'b0000, 4'b0000, 1'b1, 1'b0);
    apply_cycle(2'b01, 4'b0011, 4'b0110, 1'b1, 1'b0);
    checks++; if (q !== 4'b0001) begin fails++; $display("FAIL sr_q got=%b exp=0001", q); end
    checks++; if (chg !== 4'b0001) begin fails++; $display("FAIL sr_chg got=%b exp=0001", chg); end
`ifdef FF_BANK_SR_ERR_EN
    checks++; if (sr_err !== 1'b1) begin fails++; $display("FAIL sr_err_set got=%b exp=1", sr_err); end
`endif
    apply_cycle(2'b01, 4'b0000, 4'b0001, 1'b1, 1'b0);
    checks++; if (q !== 4'b0000) begin fails++; $display("FAIL sr_clr_q got=%b exp=0000", q); end
`ifdef FF_BANK_SR_ERR_EN
    checks++; if (sr_err !== 1'b1) begin fails++; $display("FAIL sr_err_sticky got=%b exp=1", sr_err); end
`endif
    apply_cycle(2'b01, 4'b1111, 4'b1111, 1'b1, 1'b1);
    checks++; if (q !== RV) begin fails++; $display("FAIL sr_sync_clr_q got=%b exp=%b", q, RV); end
    checks++; if (chg !== 4'b1010) begin fails++; $display("FAIL sr_sync_clr_chg got=%b exp=1010", chg); end
`ifdef FF_BANK_SR_ERR_EN
    checks++; if (sr_err !== 1'b0) begin fails++; $display("FAIL sr_err_clr got=%b exp=0", sr_err); end
`endif
  endtask

  task automatic test_d_t();
    apply_cycle(2'b10, 4'b0000, 4'b1111, 1'b1, 1'b0);
    apply_cycle(2'b10, 4'b1001, 4'b1111, 1'b1, 1'b0);
    checks++; if (q !== 4'b1001) begin fails++; $display("FAIL d_q got=%b exp=1001", q); end
    apply_cycle(2'b11, 4'b1111, 4'b0000, 1'b1, 1'b0);
    checks++; if (q !== 4'b0110) begin fails++; $display("FAIL t_q got=%b exp=0110", q); end
    checks++; if (chg !== 4'b1111) begin fails++; $display("FAIL t_chg got=%b exp=1111", chg); end
    apply_cycle(2'b11, 4'b0000, 4'b1111, 1'b1, 1'b0);
    checks++; if (q !== 4'b0110) begin fails++; $display("FAIL t0_q got=%b exp=0110", q); end
    checks++; if (chg !== 4'b0000) begin fails++; $display("FAIL t0_chg got=%b exp=0000", chg); end
    checks++; if (any_chg !== 1'b0) begin fails++; $display("FAIL t0_any got=%b exp=0", any_chg); end
  endtask

  task automatic test_clr_priority();
    apply_cycle(2'b11, 4'b1111, 4'b0000, 1'b0, 1'b1);
    checks++; if (q !== RV) begin fails++; $display("FAIL clr_q got=%b exp=%b", q, RV); end
    checks++; if (qbar !== ~RV) begin fails++; $display("FAIL clr_qbar got=%b exp=%b", qbar, ~RV); end
    checks++; if (chg !== 4'b1100) begin fails++; $display("FAIL clr_chg got=%b exp=1100", chg); end
    checks++; if (any_chg !== 1'b1) begin fails++; $display("FAIL clr_any got=%b exp=1", any_chg); end
  endtask

  task automatic test_random();
    logic [W-1:0] mq, mn, mchg;
    logic         merr;
    logic [1:0]   rm;
    logic [W-1:0] rj, rk;
    logic         re, rc;
    int           bad;
    mq   = q;
    merr = 1'b0;
`ifdef FF_BANK_SR_ERR_EN
    merr = sr_err;
`endif
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      rm = 2'($urandom_range(0, 3));
      rj = 4'($urandom);
      rk = 4'($urandom);
      re = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      mn = mq;
      for (int b = 0; b < W; b++) begin
        case (rm)
          2'b00: mn[b] = (rj[b] & ~mq[b]) | (~rk[b] & mq[b]);
          2'b01: mn[b] = rj[b] & rk[b] ? mq[b] : (rj[b] | (mq[b] & ~rk[b]));
          2'b10: mn[b] = rj[b];
          default: mn[b] = rj[b] ? ~mq[b] : mq[b];
        endcase
      end
      if (rc) begin
        mn = RV; mchg = mq ^ RV; merr = 1'b0;
      end else if (re) begin
        mchg = mq ^ mn;
        if (rm == 2'b01 && (rj & rk) != 0) merr = 1'b1;
      end else begin
        mn = mq; mchg = '0;
      end
      mq = mn;
      apply_cycle(rm, rj, rk, re, rc);
      checks++;
      if (q !== mq || qbar !== ~mq || chg !== mchg || any_chg !== (|mchg)) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand[%0d] q=%b qbar=%b chg=%b any=%b exp q=%b chg=%b", n, q, qbar, chg,
                   any_chg, mq, mchg);
      end
`ifdef FF_BANK_SR_ERR_EN
      checks++;
      if (sr_err !== merr) begin
        fails++;
        bad++;
        if (bad <= 10) $display("FAIL rand_srerr[%0d] got=%b exp=%b", n, sr_err, merr);
      end
`endif
    end
    if (merr) begin
      mq = '0;
    end
  endtask

  task automatic test_async_midop();
    apply_cycle(2'b10, 4'b0101, 4'b0000, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (q !== RV) begin fails++; $display("FAIL async_q got=%b exp=%b", q, RV); end
    checks++; if (chg !== 4'b0000) begin fails++; $display("FAIL async_chg got=%b exp=0000", chg); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_jk();
    test_sr();
    test_d_t();
    test_clr_priority();
    test_random();
    test_async_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
